regfile_mp: RTL and testbench

- Parametrised successor of the core's integer register file.
- Provides NRD combinational read ports and one synchronous write port.
- x0 is optionally hardwired to zero.
- A hardware clear sequencer zeroes the array after reset or on request, so the core can hold decode until the file is clean. Sits between decode (read) and writeback (write).

---
 rtl/regfile_mp.sv | 132 +++++++++++++
 tb/tb_regfile_mp.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised integer register file with NRD combinational read
// ports, one synchronous write port and a hardware clear sequencer.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> a read of the address being written this cycle (READY state)
//                returns the write data (write-through); x0 still reads 0
//                when ZERO_REG = 1.
//   undefined -> such a read returns the pre-write contents.
//
// Ports:
//   clk           in   sole clock, rising edge
//   rst           in   asynchronous active-low reset
//   clearReq      in   pulse: start a full clear sweep (ignored while clearing)
//   busy          out  high while the clear sweep runs; reads return 0
//   rdWrite       in   write enable
//   rdAddr        in   write address (AW bits)
//   rdData        in   write data (XLEN bits)
//   rsAddr        in   read addresses, port k at [k*AW +: AW]
//   rsData        out  read data, port k at [k*XLEN +: XLEN]
//   writeDropped  out  registered pulse: previous cycle's write was discarded
module regfile_mp #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int AW       = $clog2(NREGS),
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clearReq,
   output logic                  busy,
   input  logic                  rdWrite,
   input  logic [AW-1:0]         rdAddr,
   input  logic [XLEN-1:0]       rdData,
   input  logic [NRD*AW-1:0]     rsAddr,
   output logic [NRD*XLEN-1:0]   rsData,
   output logic                  writeDropped
);

   typedef enum logic {CLEAR, READY} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [AW-1:0]     r_idx;
   logic [AW-1:0]     w_idx_nxt;
   logic              r_wdrop;
   logic              w_wen;
   logic              w_ready_wr;
   logic [XLEN-1:0]   r_mem [NREGS];
   logic [XLEN-1:0]   w_rd  [NRD];

   // State register, sweep index and drop flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= CLEAR;
         r_idx   <= '0;
         r_wdrop <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_wdrop <= rdWrite && (r_state == CLEAR);
      end
   end

   // Next-state logic; the AW-bit index wraps to 0 when the sweep finishes
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      case (r_state)
         CLEAR: begin
            w_idx_nxt = r_idx + 1'b1;
            if (r_idx == AW'(NREGS - 1)) begin
               w_state_nxt = READY;
            end
         end
         READY: begin
            if (clearReq) begin
               w_state_nxt = CLEAR;
               w_idx_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = CLEAR;
            w_idx_nxt   = '0;
         end
      endcase
   end

   // Outputs and write qualification; busy comes straight from the state flop
   always_comb begin
      busy         = (r_state == CLEAR);
      writeDropped = r_wdrop;
      w_ready_wr   = (r_state == READY) && rdWrite;
      w_wen        = w_ready_wr && !((ZERO_REG != 0) && (rdAddr == '0));
   end

   // Storage array, deliberately not reset; the sweep zeroes it.
   // A write in the same cycle as clearReq still lands (state is READY).
   always_ff @(posedge clk) begin
      if (r_state == CLEAR) begin
         r_mem[r_idx] <= '0;
      end else if (w_wen) begin
         r_mem[rdAddr] <= rdData;
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] w_ra;
      assign w_ra = rsAddr[k*AW +: AW];
      always_comb begin
         if (busy) begin
            w_rd[k] = '0;
         end else if ((ZERO_REG != 0) && (w_ra == '0)) begin
            w_rd[k] = '0;
`ifdef REGFILE_BYPASS_EN
         end else if (w_ready_wr && (w_ra == rdAddr)) begin
            w_rd[k] = rdData;
`endif
         end else begin
            w_rd[k] = r_mem[w_ra];
         end
      end
   end

   always_comb begin
      rsData = '0;
      for (int unsigned k = 0; k < NRD; k++) begin
         rsData[k*XLEN +: XLEN] = w_rd[k];
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp (default parameters).
// A behavioural model (array plus remaining-sweep count) predicts every
// output; directed steps follow the test plan, then a randomized phase.
module tb_regfile_mp;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = 5;
   localparam int NRD   = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 clearReq;
   logic                 busy;
   logic                 rdWrite;
   logic [AW-1:0]        rdAddr;
   logic [XLEN-1:0]      rdData;
   logic [NRD*AW-1:0]    rsAddr;
   logic [NRD*XLEN-1:0]  rsData;
   logic                 writeDropped;

   int checks = 0;
   int errors = 0;

   // reference model
   logic [XLEN-1:0] m_mem [NREGS];
   int              m_left;   // entries still to be zeroed; >0 means busy
   logic            m_drop;

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1)) dut (
      .clk(clk), .rst(rst), .clearReq(clearReq), .busy(busy),
      .rdWrite(rdWrite), .rdAddr(rdAddr), .rdData(rdData),
      .rsAddr(rsAddr), .rsData(rsData), .writeDropped(writeDropped)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [XLEN-1:0] exp_rd(input int a);
      if (m_left > 0) return '0;
      if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (rdWrite && (a == int'(rdAddr))) return rdData;
`endif
      return m_mem[a];
   endfunction

   function automatic logic [XLEN-1:0] port_data(input int k);
      logic [NRD*XLEN-1:0] v;
      v = rsData;
      return v[k*XLEN +: XLEN];
   endfunction

   task automatic set_rs(input int a0, input int a1);
      rsAddr = {AW'(a1), AW'(a0)};
   endtask

   // check all outputs for the current inputs, then advance one clock
   task automatic cycle();
      logic [NRD*AW-1:0] ra;
      #1;
      ra = rsAddr;
      chk("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
      chk("writeDropped", {31'd0, writeDropped}, {31'd0, m_drop});
      for (int k = 0; k < NRD; k++)
         chk($sformatf("rs%0d[x%0d]", k, ra[k*AW +: AW]), port_data(k), exp_rd(int'(ra[k*AW +: AW])));
      if (rst) begin
         m_drop = rdWrite && (m_left > 0);
         if (m_left > 0) begin
            m_mem[NREGS - m_left] = '0;
            m_left--;
         end else begin
            if (rdWrite && rdAddr != 0) m_mem[rdAddr] = rdData;
            if (clearReq) m_left = NREGS;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset_asserted();
      rst = 1'b0;
      m_left = NREGS;
      m_drop = 1'b0;
   endtask

   task automatic idle();
      clearReq = 1'b0;
      rdWrite  = 1'b0;
      rdAddr   = '0;
      rdData   = '0;
   endtask

   // count busy cycles from now, bounded
   task automatic count_busy(input string tag, input int want);
      int n = 0;
      while (n < 100 && busy === 1'b1) begin
         n++;
         cycle();
      end
      chk(tag, XLEN'(n), XLEN'(want));
   endtask

   task automatic read_all_zero(input string tag);
      for (int i = 0; i < NREGS; i++) begin
         set_rs(i, NREGS - 1 - i);
         #1;
         chk(tag, port_data(0), '0);
         cycle();
      end
   endtask

   initial begin
      int n;
      rst = 1'b1;
      idle();
      set_rs(0, 0);
      for (int i = 0; i < NREGS; i++) m_mem[i] = 'x;
      @(posedge clk);
      #1;

      // 1. reset held 3 cycles, then exactly NREGS busy cycles
      do_reset_asserted();
      set_rs(3, 9);
      for (int i = 0; i < 3; i++) cycle();
      rst = 1'b1;
      count_busy("reset_busy_len", NREGS);
      read_all_zero("post_reset_zero");

      // 2. basic write / read, both ports on the same entry, x0 hardwired
      rdWrite = 1'b1; rdAddr = 5'd5; rdData = 32'hDEADBEEF;
      cycle();
      idle(); set_rs(5, 5);
      #1;
      chk("x5_port0", port_data(0), 32'hDEADBEEF);
      chk("x5_port1", port_data(1), 32'hDEADBEEF);
      cycle();
      rdWrite = 1'b1; rdAddr = 5'd0; rdData = 32'h1234;
      cycle();
      idle(); set_rs(0, 5);
      #1;
      chk("x0_reads_zero", port_data(0), '0);
      chk("x0_no_drop", {31'd0, writeDropped}, '0);
      cycle();

      // 3. same-cycle read of the address being written
      rdWrite = 1'b1; rdAddr = 5'd7; rdData = 32'hA5A5A5A5; set_rs(7, 7);
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("bypass_x7", port_data(0), 32'hA5A5A5A5);
`else
      chk("nobypass_x7", port_data(0), 32'h0);
`endif
      cycle();
      idle();
      #1;
      chk("x7_after", port_data(0), 32'hA5A5A5A5);
      cycle();

      // 4. fill x1..x31, then clear request
      for (int i = 1; i < NREGS; i++) begin
         rdWrite = 1'b1; rdAddr = AW'(i); rdData = XLEN'(i); set_rs(i, i - 1);
         cycle();
      end
      idle(); set_rs(17, 31);
      #1;
      chk("x17_filled", port_data(0), 32'd17);
      clearReq = 1'b1;
      cycle();
      clearReq = 1'b0;
      count_busy("clear_busy_len", NREGS);
      read_all_zero("post_clear_zero");

      // 5. write during clear is dropped
      do_reset_asserted();
      cycle();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) cycle();
      rdWrite = 1'b1; rdAddr = 5'd3; rdData = 32'hFF; clearReq = 1'b1;
      cycle();
      idle();
      #1;
      chk("drop_pulse", {31'd0, writeDropped}, 32'd1);
      cycle();
      #1;
      chk("drop_clears", {31'd0, writeDropped}, '0);
      n = 0;
      while (n < 100 && busy === 1'b1) begin n++; cycle(); end
      chk("drop_busy_len", XLEN'(n + 6), XLEN'(NREGS));
      set_rs(3, 3);
      #1;
      chk("x3_zero", port_data(0), '0);
      cycle();

      // 6. reset mid-sweep restarts the full sweep
      do_reset_asserted();
      cycle();
      rst = 1'b1;
      for (int i = 0; i < 10; i++) cycle();
      do_reset_asserted();
      cycle();
      rst = 1'b1;
      count_busy("midsweep_busy_len", NREGS);

      // 7. randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         rdWrite  = ($urandom_range(0, 2) != 0);
         rdAddr   = AW'($urandom_range(0, 7));
         rdData   = $urandom;
         clearReq = ($urandom_range(0, 59) == 0);
         set_rs($urandom_range(0, 7), $urandom_range(0, 31));
         cycle();
      end
      idle();
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
